avalon_camera_master: RTL



---
 rtl/camera_regs_pkg.sv | 48 ++++
 rtl/avalon_camera_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/camera_regs_pkg.sv
// Camera register slave address map and sequencer state encoding.
package camera_regs_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CFG_W  = 16;
  localparam int unsigned CFG_N  = 9;

  localparam logic [ADDR_W-1:0] ADDR_START_CAPTURE = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_BUFF0         = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_BUFF1         = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_BUFF0FULL     = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_BUFF1FULL     = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_START_ROW     = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_START_COLUMN  = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_ROW_SIZE      = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_COLUMN_SIZE   = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_ROW_MODE      = 4'h9;
  localparam logic [ADDR_W-1:0] ADDR_COLUMN_MODE   = 4'ha;
  localparam logic [ADDR_W-1:0] ADDR_EXPOSURE      = 4'hb;
  localparam logic [ADDR_W-1:0] ADDR_WIDTH         = 4'hc;
  localparam logic [ADDR_W-1:0] ADDR_HEIGHT        = 4'hd;
  localparam logic [ADDR_W-1:0] ADDR_SOFT_RESET_N  = 4'he;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_ARM,
    ST_POLL,
    ST_RDFLAG,
    ST_RDBUF,
    ST_RDDAT,
    ST_CLR,
    ST_WAIT,
    ST_DISARM
  } cam_state_e;

  // Full-flag register of the selected line buffer.
  function automatic logic [ADDR_W-1:0] flag_addr(input logic sel);
    return sel ? ADDR_BUFF1FULL : ADDR_BUFF0FULL;
  endfunction

  // Data register of the selected line buffer.
  function automatic logic [ADDR_W-1:0] buf_addr(input logic sel);
    return sel ? ADDR_BUFF1 : ADDR_BUFF0;
  endfunction

endpackage

// File: rtl/avalon_camera_master.sv
// Fabric-side Avalon-MM master: configures the camera slave, arms capture,
// then ping-pongs between the two line buffers, streaming each full buffer out.
module avalon_camera_master
  import camera_regs_pkg::*;
#(
  parameter logic [15:0] WIDTH        = 16'd320,
  parameter logic [15:0] HEIGHT       = 16'd240,
  parameter logic [15:0] START_ROW    = 16'h0036,
  parameter logic [15:0] START_COLUMN = 16'h0010,
  parameter logic [15:0] ROW_SIZE     = 16'h059f,
  parameter logic [15:0] COLUMN_SIZE  = 16'h077f,
  parameter logic [15:0] ROW_MODE     = 16'h0002,
  parameter logic [15:0] COLUMN_MODE  = 16'h0002,
  parameter logic [15:0] EXPOSURE     = 16'h07c0,
  parameter int unsigned POLL_GAP     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] avm_m1_address,
  output logic              avm_m1_read,
  output logic              avm_m1_write,
  output logic [DATA_W-1:0] avm_m1_writedata,
  input  logic [DATA_W-1:0] avm_m1_readdata,
  input  logic              avm_m1_waitrequest,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              pix_buf,
  output logic              busy,
  output logic [15:0]       line_count
);

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam int unsigned IDX_W = 4;

  cam_state_e       state;
  logic [IDX_W-1:0] cfg_idx;
  logic             buf_sel;
  logic             stop_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic             poll_go_c;

  // Config register values in write order (addr 0x5 upward).
  function automatic logic [CFG_W-1:0] cfg_value(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return START_ROW;
      4'd1:    return START_COLUMN;
      4'd2:    return ROW_SIZE;
      4'd3:    return COLUMN_SIZE;
      4'd4:    return ROW_MODE;
      4'd5:    return COLUMN_MODE;
      4'd6:    return EXPOSURE;
      4'd7:    return WIDTH;
      4'd8:    return HEIGHT;
      default: return 16'h0;
    endcase
  endfunction

  // A pending stop (latched or arriving now) suppresses the next flag read so
  // POLL can divert to DISARM without an outstanding transfer.
  always_comb begin
    poll_go_c = !(stop_lat || stop);
  end

  // Sequencer: every Avalon and pixel output is registered here; a request is
  // held until the cycle waitrequest is low, read data is taken the cycle after.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      cfg_idx          <= '0;
      buf_sel          <= 1'b0;
      stop_lat         <= 1'b0;
      gap_cnt          <= '0;
      avm_m1_address   <= '0;
      avm_m1_read      <= 1'b0;
      avm_m1_write     <= 1'b0;
      avm_m1_writedata <= '0;
      pix_data         <= '0;
      pix_valid        <= 1'b0;
      pix_buf          <= 1'b0;
      busy             <= 1'b0;
      line_count       <= '0;
    end else begin
      pix_valid <= 1'b0;
      if (stop) stop_lat <= 1'b1;

      case (state)
        ST_IDLE: begin
          line_count <= '0;
          buf_sel    <= 1'b0;
          cfg_idx    <= '0;
          stop_lat   <= start && stop;
          if (start) begin
            state            <= ST_CFG;
            busy             <= 1'b1;
            avm_m1_write     <= 1'b1;
            avm_m1_address   <= ADDR_START_ROW;
            avm_m1_writedata <= {16'h0, cfg_value('0)};
          end
        end

        ST_CFG: begin
          if (!avm_m1_waitrequest) begin
            if (cfg_idx == IDX_W'(CFG_N - 1)) begin
              state            <= ST_ARM;
              avm_m1_address   <= ADDR_START_CAPTURE;
              avm_m1_writedata <= 32'd1;
            end else begin
              cfg_idx          <= cfg_idx + IDX_W'(1);
              avm_m1_address   <= ADDR_START_ROW + cfg_idx + IDX_W'(1);
              avm_m1_writedata <= {16'h0, cfg_value(cfg_idx + IDX_W'(1))};
            end
          end
        end

        ST_ARM: begin
          if (!avm_m1_waitrequest) begin
            state          <= ST_POLL;
            avm_m1_write   <= 1'b0;
            avm_m1_read    <= poll_go_c;
            avm_m1_address <= flag_addr(buf_sel);
          end
        end

        ST_POLL: begin
          if (!avm_m1_read) begin
            state            <= ST_DISARM;
            avm_m1_write     <= 1'b1;
            avm_m1_address   <= ADDR_START_CAPTURE;
            avm_m1_writedata <= 32'd0;
          end else if (!avm_m1_waitrequest) begin
            state       <= ST_RDFLAG;
            avm_m1_read <= 1'b0;
          end
        end

        ST_RDFLAG: begin
          if (avm_m1_readdata[0]) begin
            state          <= ST_RDBUF;
            avm_m1_read    <= 1'b1;
            avm_m1_address <= buf_addr(buf_sel);
          end else begin
            state   <= ST_WAIT;
            gap_cnt <= '0;
          end
        end

        ST_RDBUF: begin
          if (!avm_m1_waitrequest) begin
            state       <= ST_RDDAT;
            avm_m1_read <= 1'b0;
          end
        end

        ST_RDDAT: begin
          pix_data         <= avm_m1_readdata;
          pix_buf          <= buf_sel;
          pix_valid        <= 1'b1;
          line_count       <= line_count + 16'd1;
          state            <= ST_CLR;
          avm_m1_write     <= 1'b1;
          avm_m1_address   <= flag_addr(buf_sel);
          avm_m1_writedata <= 32'd0;
        end

        ST_CLR: begin
          if (!avm_m1_waitrequest) begin
            state          <= ST_POLL;
            buf_sel        <= !buf_sel;
            avm_m1_write   <= 1'b0;
            avm_m1_read    <= poll_go_c;
            avm_m1_address <= flag_addr(!buf_sel);
          end
        end

        ST_WAIT: begin
          if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            state          <= ST_POLL;
            avm_m1_read    <= poll_go_c;
            avm_m1_address <= flag_addr(buf_sel);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        ST_DISARM: begin
          if (!avm_m1_waitrequest) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            avm_m1_write <= 1'b0;
          end
        end

        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          avm_m1_read  <= 1'b0;
          avm_m1_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
